// File: rtl/str_rr_pkt_arbiter_if.sv
// Stream bundle for str_rr_pkt_arbiter: N upstream requester ports, one downstream port,
// plus grant/busy observability. The arbiter uses the slave view, the driver the master view.
interface str_rr_pkt_arbiter_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 4
);
    localparam int unsigned IW = $clog2(N);

    logic [DW-1:0] idata [N];
    logic [N-1:0]  ilast;
    logic [N-1:0]  ivalid;
    logic [N-1:0]  iready;
    logic [DW-1:0] odata;
    logic          olast;
    logic [IW-1:0] oid;
    logic          ovalid;
    logic          oready;
    logic [N-1:0]  gnt;
    logic          busy;

    modport master (
        output idata, ilast, ivalid, oready,
        input  iready, odata, olast, oid, ovalid, gnt, busy
    );

    modport slave (
        input  idata, ilast, ivalid, oready,
        output iready, odata, olast, oid, ovalid, gnt, busy
    );
endinterface

// File: rtl/str_rr_pkt_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one valid/ready stream among N requesters.
// The output is a registered forward slice; iready is combinational from oready and ovalid.
module str_rr_pkt_arbiter #(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 4
) (
    input logic                 clk,
    input logic                 rst,
    str_rr_pkt_arbiter_if.slave bus
);
    localparam int unsigned IW = $clog2(N);

    if (N < 2) begin : g_bad_n
        $error("str_rr_pkt_arbiter: N must be >= 2");
    end

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gsel_q, gsel_d;
    logic [IW-1:0] cand;
    logic          any_valid;
    logic [DW-1:0] odata_q, odata_d;
    logic          olast_q, olast_d;
    logic [IW-1:0] oid_q, oid_d;
    logic          ovalid_q, ovalid_d;
    logic [N-1:0]  gsel_oh;
    logic          slot_free;
    logic          ish;
    logic [N-1:0]  gnt;
    logic [N-1:0]  iready;
    logic          busy;

    // First valid requester at or after ptr, wrapping modulo N.
    always_comb begin
        cand      = '0;
        any_valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!any_valid && bus.ivalid[IW'((32'(ptr_q) + k) % N)]) begin
                any_valid = 1'b1;
                cand      = IW'((32'(ptr_q) + k) % N);
            end
        end
    end

    assign slot_free = bus.oready | ~ovalid_q;
    assign gsel_oh   = N'(1) << gsel_q;
    assign ish       = (state_q == StLocked) & bus.ivalid[gsel_q] & slot_free;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gsel_d   = gsel_q;
        odata_d  = odata_q;
        olast_d  = olast_q;
        oid_d    = oid_q;
        ovalid_d = ovalid_q;
        gnt      = '0;
        iready   = '0;
        busy     = 1'b0;

        // The slice drains in either state; a load wins over a drain in the same cycle.
        if (ish) begin
            odata_d  = bus.idata[gsel_q];
            olast_d  = bus.ilast[gsel_q];
            oid_d    = gsel_q;
            ovalid_d = 1'b1;
        end else if (bus.oready) begin
            ovalid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    gsel_d  = cand;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                gnt    = gsel_oh;
                iready = slot_free ? gsel_oh : '0;
                busy   = 1'b1;
                if (ish && bus.ilast[gsel_q]) begin
                    state_d = StIdle;
                    ptr_d   = (gsel_q == IW'(N - 1)) ? '0 : gsel_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            gsel_q   <= '0;
            odata_q  <= '0;
            olast_q  <= 1'b0;
            oid_q    <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gsel_q   <= gsel_d;
            odata_q  <= odata_d;
            olast_q  <= olast_d;
            oid_q    <= oid_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign bus.odata  = odata_q;
    assign bus.olast  = olast_q;
    assign bus.oid    = oid_q;
    assign bus.ovalid = ovalid_q;
    assign bus.gnt    = gnt;
    assign bus.iready = iready;
    assign bus.busy   = busy;
endmodule

// File: tb/tb_str_rr_pkt_arbiter.sv
// Scoreboard bench for str_rr_pkt_arbiter: N=4 and N=3 instances share one stimulus source,
// expected beat order comes from a round-robin packet model built when packets are loaded.
module tb_str_rr_pkt_arbiter;
    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          mode3;
    logic [3:0]    src_valid;
    logic [3:0]    src_last;
    logic [DW-1:0] src_data [4];
    logic          t_oready;

    str_rr_pkt_arbiter_if #(.DW(DW), .N(4)) bus4 ();
    str_rr_pkt_arbiter_if #(.DW(DW), .N(3)) bus3 ();

    str_rr_pkt_arbiter #(.DW(DW), .N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    str_rr_pkt_arbiter #(.DW(DW), .N(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    assign bus4.ivalid = mode3 ? 4'b0 : src_valid;
    assign bus4.ilast  = src_last;
    assign bus4.oready = t_oready;
    assign bus3.ivalid = mode3 ? src_valid[2:0] : 3'b0;
    assign bus3.ilast  = src_last[2:0];
    assign bus3.oready = t_oready;
    for (genvar i = 0; i < 4; i++) begin : g_d4
        assign bus4.idata[i] = src_data[i];
    end
    for (genvar i = 0; i < 3; i++) begin : g_d3
        assign bus3.idata[i] = src_data[i];
    end

    logic [3:0]    obs_iready, obs_gnt;
    logic          obs_busy, obs_ovalid, obs_olast;
    logic [DW-1:0] obs_odata;
    logic [1:0]    obs_oid;
    assign obs_iready = mode3 ? {1'b0, bus3.iready} : bus4.iready;
    assign obs_gnt    = mode3 ? {1'b0, bus3.gnt} : bus4.gnt;
    assign obs_busy   = mode3 ? bus3.busy : bus4.busy;
    assign obs_ovalid = mode3 ? bus3.ovalid : bus4.ovalid;
    assign obs_olast  = mode3 ? bus3.olast : bus4.olast;
    assign obs_odata  = mode3 ? bus3.odata : bus4.odata;
    assign obs_oid    = mode3 ? bus3.oid : bus4.oid;

    int            n_checks, n_pass;
    int            cyc, seqn, stall_from, stall_len, last_cyc;
    int            mptr [2];
    int            head [4];
    int            tail [4];
    logic [DW-1:0] mem_d [4][16];
    logic          mem_l [4][16];
    bit            timing_on, first_fire, prev_last, hold_pend;
    logic [DW-1:0] held_data;
    logic          held_last;
    logic [1:0]    held_oid;
    beat_t         expq [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit srcs_empty();
        for (int r = 0; r < 4; r++) if (head[r] < tail[r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_src();
        for (int r = 0; r < 4; r++) begin
            head[r] = 0;
            tail[r] = 0;
        end
    endtask

    task automatic load_pkt(input int r, input int len);
        for (int j = 0; j < len; j++) begin
            mem_d[r][tail[r]] = 8'(r * 64 + seqn);
            mem_l[r][tail[r]] = (j == len - 1);
            tail[r]++;
            seqn = (seqn + 1) % 64;
        end
    endtask

    // Round-robin packet model over everything loaded since the last clear.
    task automatic plan(input int nreq);
        int  pidx [4];
        int  sel;
        int  m;
        bit  found;
        m = mptr[mode3 ? 1 : 0];
        for (int i = 0; i < 4; i++) pidx[i] = head[i];
        for (int p = 0; p < 64; p++) begin
            found = 1'b0;
            sel   = 0;
            for (int k = 0; k < nreq; k++) begin
                int r;
                r = (m + k) % nreq;
                if (!found && pidx[r] < tail[r]) begin
                    found = 1'b1;
                    sel   = r;
                end
            end
            if (!found) break;
            for (int j = 0; j < 16; j++) begin
                beat_t b;
                b.id   = 2'(sel);
                b.data = mem_d[sel][pidx[sel]];
                b.last = mem_l[sel][pidx[sel]];
                expq.push_back(b);
                pidx[sel]++;
                if (b.last) break;
            end
            m = (sel + 1) % nreq;
        end
        mptr[mode3 ? 1 : 0] = m;
    endtask

    task automatic drive_src();
        for (int r = 0; r < 4; r++) begin
            if (head[r] < tail[r]) begin
                src_valid[r] = 1'b1;
                src_data[r]  = mem_d[r][head[r]];
                src_last[r]  = mem_l[r][head[r]];
            end else begin
                src_valid[r] = 1'b0;
                src_data[r]  = '0;
                src_last[r]  = 1'b0;
            end
        end
    endtask

    task automatic set_oready();
        t_oready = !(cyc >= stall_from && cyc < stall_from + stall_len);
    endtask

    task automatic step();
        logic [3:0] acc;
        beat_t      e;
        @(negedge clk);
        check_val("iready_onehot0", 32'($onehot0(obs_iready)), 32'd1);
        check_val("gnt_onehot0", 32'($onehot0(obs_gnt)), 32'd1);
        check_val("busy_vs_gnt", 32'(obs_busy), 32'(|obs_gnt));
        if (hold_pend) begin
            check_val("hold_ovalid", 32'(obs_ovalid), 32'd1);
            check_val("hold_odata", 32'(obs_odata), 32'(held_data));
            check_val("hold_oid", 32'(obs_oid), 32'(held_oid));
            check_val("hold_olast", 32'(obs_olast), 32'(held_last));
        end
        if (obs_ovalid && !t_oready) check_val("iready_stall", 32'(obs_iready), 32'd0);
        if (obs_ovalid && t_oready) begin
            check_val("beat_expected", 32'(expq.size() != 0), 32'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check_val("oid", 32'(obs_oid), 32'(e.id));
                check_val("odata", 32'(obs_odata), 32'(e.data));
                check_val("olast", 32'(obs_olast), 32'(e.last));
                if (timing_on) begin
                    if (first_fire) check_val("first_latency", 32'(cyc), 32'd2);
                    else check_val("beat_gap", 32'(cyc - last_cyc), prev_last ? 32'd2 : 32'd1);
                end
                first_fire = 1'b0;
                last_cyc   = cyc;
                prev_last  = e.last;
            end
        end
        hold_pend = obs_ovalid && !t_oready;
        held_data = obs_odata;
        held_oid  = obs_oid;
        held_last = obs_olast;
        acc       = src_valid & obs_iready;
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < 4; r++) if (acc[r]) head[r]++;
        drive_src();
        set_oready();
    endtask

    task automatic start_run(input bit timing);
        cyc        = 0;
        first_fire = 1'b1;
        prev_last  = 1'b0;
        hold_pend  = 1'b0;
        timing_on  = timing;
        drive_src();
        set_oready();
    endtask

    task automatic run_test(input bit timing, input int budget);
        start_run(timing);
        for (int c = 0; c < budget; c++) begin
            if (expq.size() == 0 && srcs_empty()) break;
            step();
        end
        check_val("drained", 32'(expq.size()), 32'd0);
        check_val("idle_busy", 32'(obs_busy), 32'd0);
        check_val("idle_ovalid", 32'(obs_ovalid), 32'd0);
        stall_len = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        mode3      = 1'b0;
        t_oready   = 1'b1;
        stall_from = 0;
        stall_len  = 0;
        seqn       = 0;
        cyc        = 0;
        mptr[0]    = 0;
        mptr[1]    = 0;
        clear_src();
        drive_src();

        // Requesters 0 and 2 present packets while reset is still held.
        repeat (2) @(posedge clk);
        #1;
        load_pkt(0, 2);
        load_pkt(2, 2);
        plan(4);
        drive_src();
        @(posedge clk);
        #1;
        check_val("rst_ovalid", 32'(obs_ovalid), 32'd0);
        check_val("rst_odata", 32'(obs_odata), 32'd0);
        check_val("rst_oid", 32'(obs_oid), 32'd0);
        check_val("rst_gnt", 32'(obs_gnt), 32'd0);
        check_val("rst_iready", 32'(obs_iready), 32'd0);
        check_val("rst_busy", 32'(obs_busy), 32'd0);
        rst = 1'b0;
        run_test(1'b1, 40);

        clear_src();
        load_pkt(0, 3);
        plan(4);
        run_test(1'b1, 40);

        // ptr should now be 1, so requester 1 wins over 0.
        clear_src();
        load_pkt(0, 1);
        load_pkt(1, 1);
        plan(4);
        run_test(1'b1, 40);

        clear_src();
        load_pkt(3, 1);
        plan(4);
        run_test(1'b1, 20);

        clear_src();
        for (int p = 0; p < 3; p++) for (int r = 0; r < 4; r++) load_pkt(r, 1);
        plan(4);
        run_test(1'b1, 80);

        clear_src();
        load_pkt(1, 4);
        stall_from = 3;
        stall_len  = 5;
        plan(4);
        run_test(1'b0, 60);

        mode3 = 1'b1;
        clear_src();
        load_pkt(1, 1);
        plan(3);
        run_test(1'b1, 20);
        clear_src();
        load_pkt(2, 2);
        load_pkt(0, 1);
        load_pkt(1, 1);
        plan(3);
        run_test(1'b1, 40);
        mode3 = 1'b0;

        // Reset in the middle of a 4-beat packet from requester 3.
        clear_src();
        load_pkt(3, 4);
        plan(4);
        start_run(1'b0);
        for (int c = 0; c < 20; c++) begin
            if (head[3] >= 2) break;
            step();
        end
        check_val("mid_pkt_reached", 32'(head[3]), 32'd2);
        rst = 1'b1;
        #1;
        check_val("arst_ovalid", 32'(obs_ovalid), 32'd0);
        check_val("arst_gnt", 32'(obs_gnt), 32'd0);
        check_val("arst_busy", 32'(obs_busy), 32'd0);
        check_val("arst_iready", 32'(obs_iready), 32'd0);
        expq.delete();
        clear_src();
        drive_src();
        mptr[0] = 0;
        mptr[1] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_pkt(3, 2);
        load_pkt(0, 2);
        plan(4);
        run_test(1'b1, 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
